// File: rtl/led_pattern_gen.sv
// Multi-mode LED/PMOD pattern generator (blink, ping-pong chase, breathing, fixed level)
// with a first-order sigma-delta PDM output for the supply-trim pin.
module led_pattern_gen #(
    parameter int CHANNELS = 8,
    parameter int CNT_W    = 32,
    parameter int TAP      = 23,
    parameter int PRESCALE = 262144,
    parameter int PDM_W    = 8
) (
    input  logic                clk30,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [1:0]          mode,
    input  logic [PDM_W-1:0]    level,
    output logic [CHANNELS-1:0] led,
    output logic                tick,
    output logic                pdm_out
);

    localparam int PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int POS_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);
    localparam logic [POS_W-1:0]   POS_LAST   = POS_W'(CHANNELS - 1);
    localparam logic [PDM_W-1:0]   BRIGHT_MAX = '1;

    typedef enum logic [1:0] {
        MODE_BLINK   = 2'd0,
        MODE_CHASE   = 2'd1,
        MODE_BREATHE = 2'd2,
        MODE_LEVEL   = 2'd3
    } mode_e;

    logic [CNT_W-1:0]    cnt;
    logic [PRESC_W-1:0]  presc;
    mode_e               mode_q, mode_n;
    logic [POS_W-1:0]    pos, pos_n;
    logic                pos_down, pos_down_n;
    logic [PDM_W-1:0]    bright, bright_n;
    logic                bright_down, bright_down_n;
    logic [PDM_W:0]      out_acc, pat_acc;
    logic [PDM_W-1:0]    pat_duty;
    logic [CHANNELS-1:0] led_d;
    logic                step;
    logic                cnt_unused;

    // tick is a free-running one-cycle strobe with no ready/backpressure:
    // consumers must act in the cycle it is high or miss that step.
    assign step       = tick & enable;
    assign pat_duty   = (mode_q == MODE_BREATHE) ? bright : level;
    assign pdm_out    = out_acc[PDM_W];
    assign cnt_unused = ^cnt;

    always_comb begin
        mode_n        = mode_q;
        pos_n         = pos;
        pos_down_n    = pos_down;
        bright_n      = bright;
        bright_down_n = bright_down;
        if (step) begin
            mode_n = mode_e'(mode);
            if (mode_e'(mode) != mode_q) begin
                // A mode change restarts both patterns and consumes this tick.
                pos_n         = '0;
                pos_down_n    = 1'b0;
                bright_n      = '0;
                bright_down_n = 1'b0;
            end else if (mode_q == MODE_CHASE) begin
                if (pos_down) begin
                    pos_n = pos - 1'b1;
                    if (pos == POS_W'(1)) pos_down_n = 1'b0;
                end else begin
                    pos_n = pos + 1'b1;
                    if (pos + 1'b1 == POS_LAST) pos_down_n = 1'b1;
                end
            end else if (mode_q == MODE_BREATHE) begin
                if (bright_down) begin
                    bright_n = bright - 1'b1;
                    if (bright == PDM_W'(1)) bright_down_n = 1'b0;
                end else begin
                    bright_n = bright + 1'b1;
                    if (bright + 1'b1 == BRIGHT_MAX) bright_down_n = 1'b1;
                end
            end
        end
    end

    always_comb begin
        led_d = '0;
        case (mode_q)
            MODE_BLINK: led_d = cnt[TAP +: CHANNELS];
            MODE_CHASE: led_d = {{(CHANNELS-1){1'b0}}, 1'b1} << pos;
            default:    led_d = {CHANNELS{pat_acc[PDM_W]}};
        endcase
    end

    always_ff @(posedge clk30 or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            presc       <= '0;
            tick        <= 1'b0;
            mode_q      <= MODE_BLINK;
            pos         <= '0;
            pos_down    <= 1'b0;
            bright      <= '0;
            bright_down <= 1'b0;
            out_acc     <= '0;
            pat_acc     <= '0;
            led         <= '0;
        end else begin
            if (enable) begin
                cnt   <= cnt + 1'b1;
                presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
            end
            tick        <= enable && (presc == PRESC_LAST);
            mode_q      <= mode_n;
            pos         <= pos_n;
            pos_down    <= pos_down_n;
            bright      <= bright_n;
            bright_down <= bright_down_n;
            // Carry out of the low PDM_W bits is the PDM bit; it is dropped before the next add.
            out_acc     <= {1'b0, out_acc[PDM_W-1:0]} + {1'b0, level};
            pat_acc     <= {1'b0, pat_acc[PDM_W-1:0]} + {1'b0, pat_duty};
            led         <= led_d;
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen: directed stimulus pushes expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_led_pattern_gen;

    localparam int CHANNELS = 4;
    localparam int CNT_W    = 8;
    localparam int TAP      = 2;
    localparam int PRESCALE = 4;
    localparam int PDM_W    = 4;

    typedef struct {
        string      name;
        logic [7:0] mask;
        logic [7:0] exp;
    } chk_t;

    typedef struct {
        string      name;
        logic [7:0] exp;
        logic       sel;
    } win_t;

    // clock / reset block
    logic                clk30 = 1'b0;
    logic                rst_n;
    logic                enable;
    logic [1:0]          mode;
    logic [PDM_W-1:0]    level;
    logic [CHANNELS-1:0] led;
    logic                tick;
    logic                pdm_out;

    always #5 clk30 = ~clk30;

    led_pattern_gen #(
        .CHANNELS(CHANNELS),
        .CNT_W(CNT_W),
        .TAP(TAP),
        .PRESCALE(PRESCALE),
        .PDM_W(PDM_W)
    ) dut (
        .clk30(clk30),
        .rst_n(rst_n),
        .enable(enable),
        .mode(mode),
        .level(level),
        .led(led),
        .tick(tick),
        .pdm_out(pdm_out)
    );

    // scoreboard queues
    chk_t       cyc_q[$];
    logic [7:0] exp_q[$];
    win_t       win_q[$];

    int n_cmp    = 0;
    int n_err    = 0;
    int timeouts = 0;
    int to_seen  = 0;
    logic chase_on = 1'b0;

    int win_active = 0;
    int win_left   = 0;
    int win_ones   = 0;

    // monitor
    always @(negedge clk30) begin
        logic [7:0] obs;
        chk_t c;
        win_t w;
        logic [7:0] e;
        obs = {2'b00, pdm_out, tick, led};
        if (cyc_q.size() != 0) begin
            c = cyc_q.pop_front();
            n_cmp++;
            if ((obs & c.mask) != (c.exp & c.mask)) begin
                n_err++;
                $display("FAIL %s: got %b expected %b (mask %b)", c.name, obs & c.mask, c.exp & c.mask, c.mask);
            end
        end
        if (chase_on && tick && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({4'b0000, led} != e) begin
                n_err++;
                $display("FAIL chase_led: got %b expected %b", led, e[3:0]);
            end
        end
        if (win_active == 0 && win_q.size() != 0) begin
            win_active = 1;
            win_left   = 16;
            win_ones   = 0;
        end
        if (win_active != 0) begin
            win_ones += win_q[0].sel ? int'(pdm_out) : int'(led == 4'hF);
            win_left--;
            if (win_left == 0) begin
                w = win_q.pop_front();
                win_active = 0;
                n_cmp++;
                if (win_ones != int'(w.exp)) begin
                    n_err++;
                    $display("FAIL %s: got %0d ones in 16 cycles, expected %0d", w.name, win_ones, w.exp);
                end
            end
        end
        if (to_seen != timeouts) begin
            to_seen++;
            n_cmp++;
            n_err++;
        end
    end

    // driver tasks
    task automatic push_chk(input string name, input logic [7:0] mask, input logic [7:0] exp);
        chk_t c;
        c.name = name;
        c.mask = mask;
        c.exp  = exp;
        cyc_q.push_back(c);
    endtask

    task automatic push_win(input string name, input int exp, input logic sel);
        win_t w;
        w.name = name;
        w.exp  = 8'(exp);
        w.sel  = sel;
        win_q.push_back(w);
    endtask

    task automatic wait_tick(input string what);
        int n;
        n = 0;
        @(negedge clk30);
        while (!tick && n < 40) begin
            @(negedge clk30);
            n++;
        end
        if (!tick) begin
            $display("FAIL %s: tick stayed 0 for 40 cycles, expected a pulse", what);
            timeouts++;
        end
    endtask

    task automatic drain(input string what, input int budget);
        int n;
        n = 0;
        while ((cyc_q.size() + exp_q.size() + win_q.size()) != 0 && n < budget) begin
            @(negedge clk30);
            n++;
        end
        if ((cyc_q.size() + exp_q.size() + win_q.size()) != 0) begin
            $display("FAIL %s: %0d expectations pending after %0d cycles, expected 0",
                     what, cyc_q.size() + exp_q.size() + win_q.size(), budget);
            timeouts++;
            cyc_q.delete();
            exp_q.delete();
            win_q.delete();
        end
    endtask

    // Called just after the edge that applied a pattern step; freezes and measures duty.
    task automatic measure_led(input string name, input int exp_ones);
        enable = 1'b0;
        @(posedge clk30);
        @(posedge clk30);
        #1;
        push_win(name, exp_ones, 1'b0);
        drain(name, 40);
        @(posedge clk30);
        #1;
        enable = 1'b1;
    endtask

    task automatic level_check(input int lvl);
        level = PDM_W'(lvl);
        repeat (3) @(posedge clk30);
        #1;
        push_win($sformatf("level%0d_led", lvl), lvl, 1'b0);
        drain("level_led", 40);
        @(posedge clk30);
        #1;
        push_win($sformatf("level%0d_pdm", lvl), lvl, 1'b1);
        drain("level_pdm", 40);
    endtask

    // stimulus
    initial begin
        int k;
        int exp_b;
        logic en_now;
        logic [3:0] led_e;
        logic tick_e;
        logic [3:0] chase_seq[8];
        bit found;

        rst_n  = 1'b0;
        enable = 1'b0;
        mode   = 2'd0;
        level  = '0;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk30);
            #1;
            push_chk("reset_state", 8'h3F, 8'h00);
        end
        rst_n = 1'b1;

        // blink, counter wrap, and tick gating by enable (frozen for edges 264..273)
        k = 0;
        for (int e = 1; e <= 290; e++) begin
            en_now = !(e >= 264 && e <= 273);
            enable = en_now;
            @(posedge clk30);
            #1;
            if (en_now) begin
                k++;
                led_e  = 4'(((k - 1) % 256) >> 2);
                tick_e = (k % 4 == 0);
            end else begin
                led_e  = 4'((k % 256) >> 2);
                tick_e = 1'b0;
            end
            push_chk(en_now ? "blink_tick" : "frozen", 8'h1F, {3'b000, tick_e, led_e});
        end
        drain("blink", 10);

        // chase
        chase_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        @(posedge clk30);
        #1;
        mode = 2'd1;
        wait_tick("chase_switch");
        @(posedge clk30);
        #1;
        for (int i = 0; i < 8; i++) exp_q.push_back({4'b0000, chase_seq[i]});
        chase_on = 1'b1;
        drain("chase", 60);
        @(posedge clk30);
        #1;
        chase_on = 1'b0;

        // breathe, entered from chase: first measurement shows the restart at 0
        mode = 2'd2;
        for (int i = 0; i < 32; i++) begin
            wait_tick("breathe_tick");
            @(posedge clk30);
            #1;
            exp_b = (i <= 15) ? i : ((i <= 30) ? 30 - i : i - 30);
            measure_led($sformatf("breathe_%0d", i), exp_b);
        end

        // level and pdm_out
        @(posedge clk30);
        #1;
        mode = 2'd3;
        wait_tick("level_switch");
        @(posedge clk30);
        #1;
        level_check(0);
        level_check(5);
        level_check(15);

        // reset asserted mid-pattern, inside a tick cycle with outputs high
        wait_tick("reset_align");
        found = 1'b0;
        for (int t = 0; t < 16 && !found; t++) begin
            repeat (4) @(posedge clk30);
            #1;
            if (tick && pdm_out && led == 4'hF) found = 1'b1;
        end
        if (!found) begin
            $display("FAIL reset_align: tick/pdm_out/led never all high, expected within 16 ticks");
            timeouts++;
        end
        rst_n = 1'b0;
        push_chk("async_reset", 8'h3F, 8'h00);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk30);
            #1;
            push_chk("reset_hold", 8'h3F, 8'h00);
        end
        drain("final", 10);
        @(negedge clk30);
        @(negedge clk30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at 300000, expected to finish");
        $fatal(1, "watchdog");
    end

endmodule
